// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle between a requester and the bin2bcd_seq converter.
// The requester drives start/bin; the converter returns bcd/busy/done/ovf.
interface bin2bcd_seq_if #(
  parameter int W      = 12,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [W-1:0]          bin;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;
  logic                  ovf;

  modport master (
    output start, bin,
    input  bcd, busy, done, ovf
  );

  modport slave (
    input  start, bin,
    output bcd, busy, done, ovf
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional BIN2BCD_AUTO_EN: also convert whenever bin differs from the last accepted value.
module bin2bcd_seq #(
  parameter int W      = 12,
  parameter int DIGITS = 4
) (
  input  logic          sys_clk,
  input  logic          reset,
  bin2bcd_seq_if.slave  io
);
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + W;
  localparam int CW = $clog2(W + 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            of_q, of_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic            go;
  logic [SW-1:0]   adj;
  logic [SW-1:0]   shifted;
  logic            out_bit;

`ifdef BIN2BCD_AUTO_EN
  logic [W-1:0]    last_q, last_d;
  assign go = io.start | (io.bin != last_q);
`else
  assign go = io.start;
`endif

  // Add-3 correction per digit, no carry between digits.
  always_comb begin
    adj = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_q[W+4*i +: 4] >= 4'd5)
        adj[W+4*i +: 4] = sr_q[W+4*i +: 4] + 4'd3;
    end
    out_bit = adj[SW-1];
    shifted = {adj[SW-2:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    of_d    = of_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
`ifdef BIN2BCD_AUTO_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (go) begin
          sr_d    = {{BW{1'b0}}, io.bin};
          of_d    = 1'b0;
          cnt_d   = CW'(W);
          state_d = SHIFT;
`ifdef BIN2BCD_AUTO_EN
          last_d  = io.bin;
`endif
        end
      end
      SHIFT: begin
        sr_d  = shifted;
        of_d  = of_q | out_bit;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          bcd_d   = shifted[SW-1 -: BW];
          ovf_d   = of_q | out_bit;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      of_q    <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      of_q    <= of_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

`ifdef BIN2BCD_AUTO_EN
  always_ff @(posedge sys_clk) begin
    if (reset) last_q <= '0;
    else       last_q <= last_d;
  end
`endif

  assign io.bcd  = bcd_q;
  assign io.ovf  = ovf_q;
  assign io.done = done_q;
  assign io.busy = (state_q == SHIFT);
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: default 12-bit/4-digit and a
// 8-bit/2-digit instance for overflow.
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.W(12), .DIGITS(4)) a ();
  bin2bcd_seq_if #(.W(8),  .DIGITS(2)) b ();

  bin2bcd_seq #(.W(12), .DIGITS(4)) dut_a (
    .sys_clk (clk),
    .reset   (reset),
    .io      (a)
  );

  bin2bcd_seq #(.W(8), .DIGITS(2)) dut_b (
    .sys_clk (clk),
    .reset   (reset),
    .io      (b)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns cycles to done (-1 on timeout) and busy samples seen before it.
  task automatic wait_a(output int lat, output int bz);
    lat = -1;
    bz  = 0;
    if (a.busy) bz++;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (a.done) begin
        lat = i;
        return;
      end
      if (a.busy) bz++;
    end
  endtask

  task automatic wait_b(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (b.done) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic conv_a(input logic [11:0] v,
                        output int lat, output int bz);
    a.bin   = v;
    a.start = 1'b1;
    tick();
    a.start = 1'b0;
    wait_a(lat, bz);
  endtask

  task automatic conv_b(input logic [7:0] v, output int lat);
    b.bin   = v;
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
    wait_b(lat);
  endtask

  initial begin
    int lat, bz, nd;
    reset   = 1'b1;
    a.start = 1'b0;
    a.bin   = '0;
    b.start = 1'b0;
    b.bin   = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_bcd",  32'(a.bcd),  32'h0);
    check("rst_busy", 32'(a.busy), 32'h0);
    check("rst_done", 32'(a.done), 32'h0);
    check("rst_ovf",  32'(a.ovf),  32'h0);

    conv_a(12'd0, lat, bz);
    check("zero_lat", 32'(lat),   32'd12);
    check("zero_bcd", 32'(a.bcd), 32'h0000);
    check("zero_ovf", 32'(a.ovf), 32'h0);

    conv_a(12'd4095, lat, bz);
    check("max_lat",  32'(lat),    32'd12);
    check("max_busy", 32'(bz),     32'd12);
    check("max_bcd",  32'(a.bcd),  32'h4095);
    check("max_ovf",  32'(a.ovf),  32'h0);
    check("max_nbsy", 32'(a.busy), 32'h0);
    tick();
    check("done_1cy", 32'(a.done), 32'h0);
    check("bcd_hold", 32'(a.bcd),  32'h4095);

    conv_a(12'd1000, lat, bz);
    check("k_bcd", 32'(a.bcd), 32'h1000);
    conv_a(12'd10, lat, bz);
    check("ten_bcd", 32'(a.bcd), 32'h0010);

    // Start while busy is dropped; start held across done is accepted.
    a.bin   = 12'd1234;
    a.start = 1'b1;
    tick();
    a.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    a.bin   = 12'd999;
    a.start = 1'b1;
    wait_a(lat, bz);
    check("ign_lat", 32'(lat),   32'd8);
    check("ign_bcd", 32'(a.bcd), 32'h1234);
    tick();
    a.start = 1'b0;
    check("b2b_busy", 32'(a.busy), 32'h1);
    wait_a(lat, bz);
    check("b2b_lat", 32'(lat),   32'd12);
    check("b2b_bcd", 32'(a.bcd), 32'h0999);

    // Reset mid-conversion aborts without a done pulse.
    a.bin   = 12'd777;
    a.start = 1'b1;
    tick();
    a.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    check("abort_bcd",  32'(a.bcd),  32'h0);
    check("abort_busy", 32'(a.busy), 32'h0);
    check("abort_done", 32'(a.done), 32'h0);
    check("abort_ovf",  32'(a.ovf),  32'h0);
    a.bin = '0;
    reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (a.done) nd++;
    end
    check("abort_nodone", 32'(nd), 32'd0);

    conv_b(8'd255, lat);
    check("ov_lat", 32'(lat),   32'd8);
    check("ov_bcd", 32'(b.bcd), 32'h55);
    check("ov_flg", 32'(b.ovf), 32'h1);
    conv_b(8'd99, lat);
    check("nov_bcd", 32'(b.bcd), 32'h99);
    check("nov_flg", 32'(b.ovf), 32'h0);
    conv_b(8'd100, lat);
    check("c_bcd", 32'(b.bcd), 32'h00);
    check("c_flg", 32'(b.ovf), 32'h1);

`ifdef BIN2BCD_AUTO_EN
    reset = 1'b1;
    a.bin = '0;
    tick();
    reset = 1'b0;
    tick();
    a.bin = 12'd42;
    wait_a(lat, bz);
    check("auto_lat", 32'(lat),   32'd13);
    check("auto_bcd", 32'(a.bcd), 32'h0042);
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (a.done) nd++;
    end
    check("auto_idle", 32'(nd), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
